// File: rtl/uart_tx_core_if.sv
// Byte handshake between the UART register block and the transmitter.
interface uart_tx_core_if;
   logic       send;
   logic [7:0] dout;
   logic       busy;

   modport master (output send, output dout, input busy);
   modport slave  (input send, input dout, output busy);
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter paced by a bit-rate enable strobe.
// Define UART_TX_INT_BAUD_EN to derive the bit tick from an internal BUS_CLK/BAUD divider.
module uart_tx_core #(
   parameter int BUS_CLK = 10_000_000,
   parameter int BAUD    = 9_600
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_en,
   output logic tx,
   uart_tx_core_if.slave bus
);

   generate
      if (BUS_CLK < BAUD) begin : g_bad_rate
         $error("uart_tx_core: BUS_CLK must not be below BAUD");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t     state_reg, state_next;
   logic [7:0] shift_reg, shift_next;
   logic [2:0] cnt_reg, cnt_next;
   logic       tx_reg, tx_next;
   logic       busy_reg, busy_next;
   logic       stop_reg, stop_next;
   logic       accept;
   logic       tick;

`ifdef UART_TX_INT_BAUD_EN
   localparam int DIV = BUS_CLK / BAUD;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [DW-1:0] div_reg;

   // Restarting on acceptance makes the start bit a full period long.
   always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
         div_reg <= '0;
      end else if (clk_en) begin
         div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      end
   end

   assign tick = clk_en && (div_reg == DIV_LAST);
`else
   assign tick = clk_en;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         cnt_reg   <= '0;
         tx_reg    <= 1'b1;
         busy_reg  <= 1'b0;
         stop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
         tx_reg    <= tx_next;
         busy_reg  <= busy_next;
         stop_reg  <= stop_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      cnt_next   = cnt_reg;
      tx_next    = tx_reg;
      busy_next  = busy_reg;
      stop_next  = stop_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
            if (bus.send) begin
               accept     = 1'b1;
               shift_next = bus.dout;
               busy_next  = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (tick) begin
               tx_next    = 1'b0;
               cnt_next   = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               tx_next    = shift_reg[0];
               shift_next = {1'b0, shift_reg[7:1]};
               cnt_next   = cnt_reg + 3'd1;
               if (cnt_reg == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            // First tick drives the stop bit, the second one ends it.
            if (tick) begin
               if (!stop_reg) begin
                  tx_next   = 1'b1;
                  stop_next = 1'b1;
               end else begin
                  busy_next  = 1'b0;
                  stop_next  = 1'b0;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign tx       = tx_reg;
   assign bus.busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: reset, frame timing, back-to-back, ignored send, strobe pacing, abort.
module tb_uart_tx_core;

`ifdef UART_TX_INT_BAUD_EN
   localparam int DIVP  = 10;
   localparam int P_BUS = 10_000_000;
   localparam int P_BD  = 1_000_000;
`else
   localparam int DIVP  = 1;
   localparam int P_BUS = 10_000_000;
   localparam int P_BD  = 9_600;
`endif
   localparam int LIMIT = 2000;

   logic clk;
   logic rst_n;
   logic clk_en;
   logic tx;
   int   total;
   int   bad;
   bit   en4;
   int   en_ph;

   uart_tx_core_if bus_if ();

   uart_tx_core #(.BUS_CLK(P_BUS), .BAUD(P_BD)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .tx     (tx),
      .bus    (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe is either tied high or pulses once every fourth clock.
   always @(negedge clk) begin
      if (en4) begin
         en_ph  = (en_ph + 1) % 4;
         clk_en = (en_ph == 0);
      end else begin
         clk_en = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus_if.busy !== 1'b0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, bus_if.busy}, 32'd0);
   endtask

   // Finds the start bit, then checks the first and last clock of each of nbits frame bits.
   task automatic rx_frame(input int p, input logic [7:0] b, input int nbits, input string tag);
      logic [9:0] fr;
      logic [7:0] got;
      int         n;
      fr  = {1'b1, b, 1'b0};
      got = '0;
      n   = 0;
      while (tx !== 1'b0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) begin
         chk({tag, "_start_timeout"}, {31'd0, tx}, 32'd0);
         return;
      end
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < p; c++) begin
            if (c == 0 || c == p - 1)
               chk($sformatf("%s_bit%0d_c%0d", tag, i, c), {31'd0, tx}, {31'd0, fr[i]});
            if (c == 0 && i >= 1 && i <= 8)
               got[i-1] = tx;
            if (!(i == nbits - 1 && c == p - 1))
               @(negedge clk);
         end
      end
      if (nbits == 10) begin
         chk({tag, "_byte"}, {24'd0, got}, {24'd0, b});
         $display("frame %s sent=%02h received=%02h", tag, b, got);
      end
   endtask

   task automatic send_pulse(input logic [7:0] b, input string tag);
      bus_if.send = 1'b1;
      bus_if.dout = b;
      @(negedge clk);
      chk({tag, "_accept_busy"}, {31'd0, bus_if.busy}, 32'd1);
      bus_if.send = 1'b0;
      bus_if.dout = 8'h00;
   endtask

   initial begin
      logic [9:0] seq;
      logic [7:0] b;
      total       = 0;
      bad         = 0;
      en4         = 1'b0;
      en_ph       = 0;
      clk_en      = 1'b1;
      rst_n       = 1'b0;
      bus_if.send = 1'b0;
      bus_if.dout = 8'h00;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("reset_tx_%0d", i), {31'd0, tx}, 32'd1);
         chk($sformatf("reset_busy_%0d", i), {31'd0, bus_if.busy}, 32'd0);
      end

      // 0xA5: start, 1,0,1,0,0,1,0,1, stop
      seq = 10'b1101001010;
`ifndef UART_TX_INT_BAUD_EN
      bus_if.send = 1'b1;
      bus_if.dout = 8'hA5;
      @(negedge clk);
      chk("a5_e1_busy", {31'd0, bus_if.busy}, 32'd1);
      chk("a5_e1_tx", {31'd0, tx}, 32'd1);
      bus_if.send = 1'b0;
      bus_if.dout = 8'h00;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("a5_e%0d_tx", k + 2), {31'd0, tx}, {31'd0, seq[k]});
         chk($sformatf("a5_e%0d_busy", k + 2), {31'd0, bus_if.busy}, 32'd1);
      end
      @(negedge clk);
      chk("a5_e12_busy", {31'd0, bus_if.busy}, 32'd0);
      $display("frame a5 exact-edge sequence checked");
`else
      send_pulse(8'hA5, "a5");
      rx_frame(DIVP, 8'hA5, 10, "a5");
      wait_idle("a5_idle");
`endif

      for (int f = 0; f < 32; f++) begin
         b = 8'($urandom_range(0, 255));
         wait_idle($sformatf("b2b%0d_idle", f));
         send_pulse(b, $sformatf("b2b%0d", f));
         rx_frame(DIVP, b, 10, $sformatf("b2b%0d", f));
      end

      // send during an 0xFF frame is ignored; held high it starts 0x3C once idle.
      wait_idle("ff_idle");
      send_pulse(8'hFF, "ff");
      fork
         begin
            rx_frame(DIVP, 8'hFF, 10, "ff");
            rx_frame(DIVP, 8'h3C, 10, "3c");
         end
         begin
            int n = 0;
            repeat (5 * DIVP) @(negedge clk);
            bus_if.send = 1'b1;
            bus_if.dout = 8'h3C;
            while (bus_if.busy !== 1'b0 && n < LIMIT) begin
               @(negedge clk);
               n++;
            end
            chk("3c_wait_idle", {31'd0, bus_if.busy}, 32'd0);
            @(negedge clk);
            chk("3c_accept_busy", {31'd0, bus_if.busy}, 32'd1);
            bus_if.send = 1'b0;
            bus_if.dout = 8'h00;
         end
      join

      // 0x81 with a strobe every 4 clocks, aborted by reset during data bit 3.
      wait_idle("x81_idle");
      en4 = 1'b1;
      send_pulse(8'h81, "x81");
      rx_frame(4 * DIVP, 8'h81, 4, "x81");
      @(negedge clk);
      chk("x81_bit3", {31'd0, tx}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("x81_abort_tx", {31'd0, tx}, 32'd1);
      chk("x81_abort_busy", {31'd0, bus_if.busy}, 32'd0);
      rst_n = 1'b1;
      en4   = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_abort_tx", {31'd0, tx}, 32'd1);
      chk("post_abort_busy", {31'd0, bus_if.busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial transmitter for the peripheral UART. It accepts one byte per handshake and shifts it out on a single line as an 8N1 frame: start bit, 8 data bits LSB first, one stop bit. Bit timing is driven by a bit-rate enable strobe. It sits between the bus-side UART register block and the TX pin.

## Interface
Parameters:
- BUS_CLK, 10_000_000: bus clock frequency in Hz.
- BAUD, 9_600: line bit rate in bits/s. Used only with the internal divider (see Configuration). Elaboration must fail if BUS_CLK < BAUD.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- clk_en  in  1  bit-rate enable strobe; one high cycle = one bit period tick.
- tx  out  1  serial line, registered, idles high.
- send  in  1  request to transmit dout; level-sampled each clk.
- dout  in  8  byte to transmit; sampled only on acceptance.
- busy  out  1  high while a frame is accepted and not complete.

## Operation
- Reset (rst_n=0 at a rising edge): tx=1, busy=0, state IDLE, shift register and bit counter cleared. This applies mid-frame too: the frame is aborted and the line returns high at that edge.
- Define tick = clk_en when the divider is compiled out.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0.
  - If send=1, accept the request: latch dout into an 8-bit shift register, set busy=1, go to START.
  - Acceptance does not need a tick.
- START: on tick, tx<=0, bit counter<=0, go to DATA.
- DATA: on each tick, tx<=shift[0], shift right, counter+1. The tick that drives bit 7 moves to STOP.
- STOP: on the next tick, tx<=1 and the stop bit begins. On the following tick, busy<=0 and go to IDLE.
  - Track this with a 1-bit "stop driven" flag inside STOP.
- Without a tick, all state, tx and busy hold.
- send while busy=1 is ignored; there is no queueing.
- dout changes after acceptance do not affect the frame in flight.
- send held high continuously starts a new frame at the first IDLE cycle, giving back-to-back frames.

## Timing
With clk_en tied high, for a request accepted at edge E1:
- E1: busy=1, tx still 1.
- E2: tx=0 (start bit).
- E3..E10: tx = dout[0]..dout[7].
- E11: tx=1 (stop bit).
- E12: busy=0, state IDLE.
- E13: earliest next acceptance.

Each bit is held exactly one tick interval, so all bits have full width. Frame length is 10 bit periods. busy is high from the acceptance edge through the end of the stop bit.

## Configuration
Macro UART_TX_INT_BAUD_EN.
- Defined: an internal counter of width $clog2(BUS_CLK/BAUD) counts enabled cycles (clk_en=1) and produces tick once every BUS_CLK/BAUD enabled cycles. Divisor is integer-truncated.
  - The counter resets to 0 on reset and on acceptance, so the first tick is a full period after send.
- Not defined: tick = clk_en, and BUS_CLK/BAUD are used only for the elaboration check.

## Test plan
All scenarios with the macro undefined unless noted.
- Reset, clk_en=1: after rst_n released, tx=1 and busy=0 are held with send=0 for 10 cycles.
- dout=0xA5, send pulsed 1 cycle, clk_en=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1 on E2..E11; busy falls at E12.
- Random bytes back-to-back, each send issued as soon as busy=0, ~32 frames -> every received byte equals the sent byte and every stop bit =1.
- send=1 with dout=0x3C asserted mid-frame of 0xFF -> ignored, 0xFF frame unaltered; 0x3C is sent only if send is still high once idle.
- clk_en pulsing every 4th cycle, dout=0x81 -> each bit lasts exactly 4 clk; rst_n=0 during bit 3 -> tx=1 and busy=0 at the next edge.
- Macro defined, BUS_CLK=10_000_000, BAUD=1_000_000, clk_en=1 -> each bit lasts 10 clk.
